// File: rtl/open_loop_send_engine.sv
// Send-side loop of the open-loop TCP benchmark: pops {cmd, flowid} entries, fetches the
// flow context, issues one TX payload request, writes back the request count and requeues.
module open_loop_send_engine #(
  parameter int FLOWID_W        = 8,
  parameter int REQ_W           = 32,
  parameter int SIZE_W          = 16,
  parameter int CTRL_RESP_BYTES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  // send loop queue (FWFT read side, write side for requeue)
  input  logic                        send_q_empty,
  input  logic [FLOWID_W:0]           send_q_rd_data,
  output logic                        send_q_rd_req,
  input  logic                        send_q_full,
  output logic                        send_q_wr_req,
  output logic [FLOWID_W:0]           send_q_wr_data,
  // app context memory
  output logic                        app_mem_rd_req_val,
  input  logic                        app_mem_rd_req_rdy,
  output logic [FLOWID_W-1:0]         app_mem_rd_req_addr,
  input  logic                        app_mem_rd_resp_val,
  input  logic [2*REQ_W+SIZE_W:0]     app_mem_rd_resp_data,
  output logic                        app_mem_wr_val,
  input  logic                        app_mem_wr_rdy,
  output logic [FLOWID_W-1:0]         app_mem_wr_addr,
  output logic [2*REQ_W+SIZE_W:0]     app_mem_wr_data,
  // TX payload request / response
  output logic                        tx_req_val,
  input  logic                        tx_req_rdy,
  output logic [FLOWID_W-1:0]         tx_req_flowid,
  output logic [SIZE_W-1:0]           tx_req_len,
  input  logic                        tx_resp_val,
  input  logic                        tx_resp_ok,
  output logic                        tx_resp_rdy,
  // completion, statistics, status
  output logic                        conn_done_val,
  output logic [FLOWID_W-1:0]         conn_done_flowid,
  output logic [31:0]                 stat_tx_reqs,
  output logic                        busy,
  output logic [2:0]                  dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where val and rdy are both high;
  // val and its payload stay constant until that edge. rd_resp has no rdy (always taken).

  localparam logic CMD_CTRL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_RD, S_MEM_WAIT, S_TX_REQ, S_TX_RESP, S_WB, S_REQUEUE
  } state_t;

  state_t state_q, state_d;

  logic                cmd_q;
  logic [FLOWID_W-1:0] flowid_q;
  logic [REQ_W-1:0]    total_q;
  logic [REQ_W-1:0]    curr_inc_q;
  logic [SIZE_W-1:0]   bufsize_q;
  logic [SIZE_W-1:0]   len_q;
  logic                copy_q;
  logic                conn_done_q;
  logic [31:0]         stat_q;

  logic pop, latch_ctx, tx_granted, done_set;

  logic [REQ_W-1:0]  rsp_total;
  logic [REQ_W-1:0]  rsp_curr;
  logic [SIZE_W-1:0] rsp_bufsize;
  logic              rsp_copy;

  assign rsp_total   = app_mem_rd_resp_data[2*REQ_W+SIZE_W -: REQ_W];
  assign rsp_curr    = app_mem_rd_resp_data[SIZE_W+1 +: REQ_W];
  assign rsp_bufsize = app_mem_rd_resp_data[1 +: SIZE_W];
  assign rsp_copy    = app_mem_rd_resp_data[0];

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    latch_ctx  = 1'b0;
    tx_granted = 1'b0;
    done_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!send_q_empty) begin
          pop     = 1'b1;
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (app_mem_rd_req_rdy) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (app_mem_rd_resp_val) begin
          latch_ctx = 1'b1;
          if (cmd_q == CMD_CTRL) begin
            state_d = S_TX_REQ;
          end else if (rsp_curr >= rsp_total) begin
            // budget already spent (includes total_reqs == 0): finish without sending
            done_set = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_TX_REQ;
          end
        end
      end
      S_TX_REQ: begin
        if (tx_req_rdy) state_d = S_TX_RESP;
      end
      S_TX_RESP: begin
        if (tx_resp_val) begin
          if (tx_resp_ok) begin
            tx_granted = 1'b1;
            if (cmd_q == CMD_CTRL) state_d = S_IDLE;
            else                   state_d = S_WB;
          end else begin
            state_d = S_REQUEUE;
          end
        end
      end
      S_WB: begin
        if (app_mem_wr_rdy) begin
          if (curr_inc_q < total_q) begin
            state_d = S_REQUEUE;
          end else begin
            done_set = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_REQUEUE: begin
        if (!send_q_full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= 1'b0;
      flowid_q    <= '0;
      total_q     <= '0;
      curr_inc_q  <= '0;
      bufsize_q   <= '0;
      len_q       <= '0;
      copy_q      <= 1'b0;
      conn_done_q <= 1'b0;
      stat_q      <= '0;
    end else begin
      state_q     <= state_d;
      conn_done_q <= done_set;
      if (pop) begin
        cmd_q    <= send_q_rd_data[FLOWID_W];
        flowid_q <= send_q_rd_data[FLOWID_W-1:0];
      end
      if (latch_ctx) begin
        total_q    <= rsp_total;
        // stored pre-incremented; the write-back and the budget test both use curr+1
        curr_inc_q <= rsp_curr + REQ_W'(1);
        bufsize_q  <= rsp_bufsize;
        copy_q     <= rsp_copy;
        if (cmd_q == CMD_CTRL) len_q <= SIZE_W'(CTRL_RESP_BYTES);
        else                   len_q <= rsp_bufsize;
      end
      if (tx_granted) stat_q <= stat_q + 32'd1;
    end
  end

  assign send_q_rd_req       = pop;
  assign send_q_wr_req       = (state_q == S_REQUEUE) && !send_q_full;
  assign send_q_wr_data      = {1'b0, flowid_q};
  assign app_mem_rd_req_val  = (state_q == S_MEM_RD);
  assign app_mem_rd_req_addr = flowid_q;
  assign app_mem_wr_val      = (state_q == S_WB);
  assign app_mem_wr_addr     = flowid_q;
  assign app_mem_wr_data     = {total_q, curr_inc_q, bufsize_q, copy_q};
  assign tx_req_val          = (state_q == S_TX_REQ);
  assign tx_req_flowid       = flowid_q;
  assign tx_req_len          = len_q;
  assign tx_resp_rdy         = (state_q == S_TX_RESP);
  assign conn_done_val       = conn_done_q;
  assign conn_done_flowid    = flowid_q;
  assign stat_tx_reqs        = stat_q;
  assign busy                = (state_q != S_IDLE);
  assign dbg_state           = state_q;

endmodule
